// File: rtl/ex_unit_pkg.sv
// Shared types for the MangoMIPS32 execute stage: ALU op codes, word constants
// and the divider FSM states.
package ex_unit_pkg;

  localparam int          WORD_W    = 32;
  localparam int          ALU_OP_W  = 5;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP   = 5'd0,
    ALU_AND   = 5'd1,
    ALU_OR    = 5'd2,
    ALU_XOR   = 5'd3,
    ALU_NOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_ADDU  = 5'd8,
    ALU_SUBU  = 5'd9,
    ALU_ADD   = 5'd10,
    ALU_SUB   = 5'd11,
    ALU_SLT   = 5'd12,
    ALU_SLTU  = 5'd13,
    ALU_MOVZ  = 5'd14,
    ALU_MOVN  = 5'd15,
    ALU_LUI   = 5'd16,
    ALU_MULT  = 5'd17,
    ALU_MULTU = 5'd18,
    ALU_DIV   = 5'd19,
    ALU_DIVU  = 5'd20,
    ALU_MFHI  = 5'd21,
    ALU_MFLO  = 5'd22,
    ALU_MTHI  = 5'd23,
    ALU_MTLO  = 5'd24
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/ex_unit_div.sv
// div_unit: iterative restoring divider (IDLE -> BUSY -> DONE) with sign handling,
// used by ex_unit when MANGO_DIV_EN is defined.
module div_unit
  import ex_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int             CW   = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DIV_CYCLES - 1);

  div_state_e    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   q_r, r_r, b_r, dividend_r;
  logic          neg_q, neg_r, b_zero;
  logic [32:0]   shifted, diff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = DIV_BUSY;
      DIV_BUSY: if (cnt == LAST) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor; a borrow in bit 32 means the step restores.
  assign shifted = {r_r, q_r[31]};
  assign diff    = shifted - {1'b0, b_r};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      q_r        <= '0;
      r_r        <= '0;
      b_r        <= '0;
      dividend_r <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      b_zero     <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt        <= '0;
      q_r        <= (signed_op && a[31]) ? -a : a;
      r_r        <= '0;
      b_r        <= (signed_op && b[31]) ? -b : b;
      dividend_r <= a;
      neg_q      <= signed_op & (a[31] ^ b[31]);
      neg_r      <= signed_op & a[31];
      b_zero     <= (b == ZERO_WORD);
    end else if (state == DIV_BUSY) begin
      cnt <= cnt + 1'b1;
      if (!diff[32]) begin
        r_r <= diff[31:0];
        q_r <= {q_r[30:0], 1'b1};
      end else begin
        r_r <= shifted[31:0];
        q_r <= {q_r[30:0], 1'b0};
      end
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);
  assign quot = b_zero ? 32'hFFFF_FFFF : (neg_q ? -q_r : q_r);
  assign rem  = b_zero ? dividend_r    : (neg_r ? -r_r : r_r);

endmodule

// File: rtl/ex_unit.sv
// MangoMIPS32 execute stage: ALU, HI/LO, EX forwarding and EX/MEM latch.
// Define MANGO_DIV_EN to build the iterative divider and its pipeline stall.
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [4:0]  aluop,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        wreg,
  input  logic [4:0]  wraddr,
  output logic        ex_wreg,
  output logic [4:0]  ex_wraddr,
  output logic [31:0] ex_wrdata,
  output logic        ex_stallreq,
  output logic        mem_wreg,
  output logic [4:0]  mem_wraddr,
  output logic [31:0] mem_wrdata,
  output logic        ovf
);

  if (DIV_CYCLES != WORD_W) begin : g_bad_cfg
    $error("DIV_CYCLES must equal the data width");
  end

  alu_op_e     op;
  logic [31:0] hi, lo, result;
  logic [32:0] sum33;
  logic [63:0] mul_a, mul_b, prod;
  logic        known, overflow, hilo_op, is_div, mul_signed;
  logic        div_done;
  logic [31:0] div_quot, div_rem;

  assign op = alu_op_e'(aluop);

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    result   = ZERO_WORD;
    sum33    = '0;
    known    = 1'b1;
    overflow = 1'b0;
    hilo_op  = 1'b0;
    is_div   = 1'b0;
    case (op)
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_NOR:  result = ~(op1 | op2);
      ALU_SLL:  result = op2 << op1[4:0];
      ALU_SRL:  result = op2 >> op1[4:0];
      ALU_SRA:  result = $signed(op2) >>> op1[4:0];
      ALU_ADDU: result = op1 + op2;
      ALU_SUBU: result = op1 - op2;
      ALU_ADD: begin
        sum33    = {op1[31], op1} + {op2[31], op2};
        result   = sum33[31:0];
        overflow = sum33[32] ^ sum33[31];
      end
      ALU_SUB: begin
        sum33    = {op1[31], op1} - {op2[31], op2};
        result   = sum33[31:0];
        overflow = sum33[32] ^ sum33[31];
      end
      ALU_SLT:  result = {31'b0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {31'b0, op1 < op2};
      ALU_MOVZ, ALU_MOVN, ALU_LUI: result = op1;
      ALU_MULT, ALU_MULTU, ALU_MTHI, ALU_MTLO: hilo_op = 1'b1;
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
`ifdef MANGO_DIV_EN
      ALU_DIV, ALU_DIVU: begin
        hilo_op = 1'b1;
        is_div  = 1'b1;
      end
`endif
      default:  known = 1'b0;
    endcase
  end

  // The low 64 bits of a product of 64-bit extensions are correct for both
  // signed and unsigned operands, so one multiplier serves MULT and MULTU.
  assign mul_signed = (op == ALU_MULT);
  assign mul_a      = {{32{mul_signed & op1[31]}}, op1};
  assign mul_b      = {{32{mul_signed & op2[31]}}, op2};
  assign prod       = mul_a * mul_b;

`ifdef MANGO_DIV_EN
  logic div_busy, div_done_q, div_start;

  // The divide bundle is still held in the cycle after DONE; div_done_q keeps
  // it from re-arming the divider before ID advances.
  assign div_start = i_valid & is_div & ~div_busy & ~div_done & ~div_done_q;

  div_unit #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .signed_op (op == ALU_DIV),
    .a         (op1),
    .b         (op2),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_done_q <= 1'b0;
    else         div_done_q <= div_done;
  end

  assign ex_stallreq = div_start | div_busy | div_done;
`else
  assign div_done    = 1'b0;
  assign div_quot    = ZERO_WORD;
  assign div_rem     = ZERO_WORD;
  assign ex_stallreq = 1'b0;
`endif

  assign ex_wreg   = i_valid & wreg & known & ~overflow & ~hilo_op & ~ex_stallreq;
  assign ex_wraddr = wraddr;
  assign ex_wrdata = result;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= ZERO_WORD;
      lo <= ZERO_WORD;
    end else if (div_done) begin
      lo <= div_quot;
      hi <= div_rem;
    end else if (i_valid && !ex_stallreq) begin
      case (op)
        ALU_MULT, ALU_MULTU: {hi, lo} <= prod;
        ALU_MTHI: hi <= op1;
        ALU_MTLO: lo <= op1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_wreg   <= 1'b0;
      mem_wraddr <= 5'd0;
      mem_wrdata <= ZERO_WORD;
      ovf        <= 1'b0;
    end else begin
      mem_wreg   <= ex_wreg;
      mem_wraddr <= ex_wraddr;
      mem_wrdata <= ex_wrdata;
      ovf        <= i_valid & overflow & ~ex_stallreq;
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
// Directed self-checking bench for ex_unit; expectations follow MANGO_DIV_EN.
module tb_ex_unit;
  import ex_unit_pkg::*;

`ifdef MANGO_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, wreg;
  logic [4:0]  aluop, wraddr;
  logic [31:0] op1, op2;
  logic        ex_wreg, ex_stallreq, mem_wreg, ovf;
  logic [4:0]  ex_wraddr, mem_wraddr;
  logic [31:0] ex_wrdata, mem_wrdata;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] hi_exp, lo_exp;

  always #5 clk = ~clk;

  ex_unit #(.DIV_CYCLES(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_valid     (i_valid),
    .aluop       (aluop),
    .op1         (op1),
    .op2         (op2),
    .wreg        (wreg),
    .wraddr      (wraddr),
    .ex_wreg     (ex_wreg),
    .ex_wraddr   (ex_wraddr),
    .ex_wrdata   (ex_wrdata),
    .ex_stallreq (ex_stallreq),
    .mem_wreg    (mem_wreg),
    .mem_wraddr  (mem_wraddr),
    .mem_wrdata  (mem_wrdata),
    .ovf         (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic present(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic w, input logic [4:0] addr);
    @(negedge clk);
    i_valid = 1'b1;
    aluop   = op;
    op1     = a;
    op2     = b;
    wreg    = w;
    wraddr  = addr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag);
    present(ALU_MFLO, 32'h0, 32'h0, 1'b1, 5'd1);
    check({tag, "_lo"}, ex_wrdata, lo_exp);
    present(ALU_MFHI, 32'h0, 32'h0, 1'b1, 5'd1);
    check({tag, "_hi"}, ex_wrdata, hi_exp);
  endtask

  task automatic run_div(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int cycles = 0;
    logic mem_bad = 1'b0;
    present(op, a, b, 1'b1, 5'd9);
    check({tag, "_ex_wreg"}, ex_wreg, 1'b0);
    while (ex_stallreq && cycles < 100) begin
      cycles++;
      step();
      if (mem_wreg !== 1'b0) mem_bad = 1'b1;
    end
    check({tag, "_stall_cycles"}, cycles, DIV_ON ? 32'd34 : 32'd0);
    check({tag, "_bubble"}, mem_bad, 1'b0);
    if (DIV_ON) begin
      lo_exp = q;
      hi_exp = r;
    end
    read_hilo(tag);
  endtask

  initial begin
    resetn  = 1'b0;
    i_valid = 1'b0;
    aluop   = ALU_NOP;
    op1     = '0;
    op2     = '0;
    wreg    = 1'b0;
    wraddr  = '0;
    #3;
    check("rst_mem_wreg", mem_wreg, 1'b0);
    check("rst_mem_wraddr", mem_wraddr, 5'd0);
    check("rst_mem_wrdata", mem_wrdata, 32'h0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_stall", ex_stallreq, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Signed overflow suppresses the write and flags ovf one cycle later.
    present(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd5);
    check("add_ovf_ex_wreg", ex_wreg, 1'b0);
    step();
    check("add_ovf_flag", ovf, 1'b1);
    check("add_ovf_mem_wreg", mem_wreg, 1'b0);

    present(ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd5);
    check("addu_data", ex_wrdata, 32'h8000_0000);
    check("addu_ex_wreg", ex_wreg, 1'b1);
    check("addu_ex_wraddr", ex_wraddr, 5'd5);
    step();
    check("addu_mem_data", mem_wrdata, 32'h8000_0000);
    check("addu_mem_wreg", mem_wreg, 1'b1);
    check("addu_mem_wraddr", mem_wraddr, 5'd5);
    check("addu_ovf_clear", ovf, 1'b0);

    present(ALU_SUB, 32'h8000_0000, 32'h1, 1'b1, 5'd6);
    check("sub_ovf_ex_wreg", ex_wreg, 1'b0);
    present(ALU_SUB, 32'h5, 32'h7, 1'b1, 5'd6);
    check("sub_data", ex_wrdata, 32'hFFFF_FFFE);
    check("sub_ex_wreg", ex_wreg, 1'b1);
    present(ALU_SRA, 32'h4, 32'h8000_0000, 1'b1, 5'd7);
    check("sra", ex_wrdata, 32'hF800_0000);
    present(ALU_SRL, 32'h4, 32'h8000_0000, 1'b1, 5'd7);
    check("srl", ex_wrdata, 32'h0800_0000);
    present(ALU_SLL, 32'h1F, 32'h3, 1'b1, 5'd7);
    check("sll", ex_wrdata, 32'h8000_0000);
    present(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd8);
    check("slt", ex_wrdata, 32'h1);
    present(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd8);
    check("sltu", ex_wrdata, 32'h0);
    present(ALU_NOR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 5'd8);
    check("nor", ex_wrdata, 32'h0F0F_F0F0);
    present(alu_op_e'(5'd31), 32'h1234, 32'h5678, 1'b1, 5'd8);
    check("unknown_data", ex_wrdata, 32'h0);
    check("unknown_ex_wreg", ex_wreg, 1'b0);

    // MULT writes HI/LO only; the GPR write request is ignored.
    present(ALU_MULT, 32'hFFFF_FFFF, 32'h2, 1'b1, 5'd10);
    check("mult_ex_wreg", ex_wreg, 1'b0);
    hi_exp = 32'hFFFF_FFFF;
    lo_exp = 32'hFFFF_FFFE;
    read_hilo("mult");
    present(ALU_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1, 5'd10);
    hi_exp = 32'h0000_0001;
    read_hilo("multu");

    run_div("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_zero", ALU_DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5);
    run_div("div_minint", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);

    present(ALU_MTHI, 32'h1234_5678, 32'h0, 1'b0, 5'd0);
    present(ALU_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0, 5'd0);
    hi_exp = 32'h1234_5678;
    lo_exp = 32'h9ABC_DEF0;
    read_hilo("mt");

    // Reset in the middle of a divide aborts it and clears HI/LO.
    present(ALU_DIV, 32'd100, 32'd7, 1'b1, 5'd2);
    repeat (10) step();
    @(negedge clk);
    resetn  = 1'b0;
    i_valid = 1'b0;
    #1;
    check("abort_stall", ex_stallreq, 1'b0);
    check("abort_mem_wreg", mem_wreg, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    hi_exp = 32'h0;
    lo_exp = 32'h0;
    read_hilo("abort");
    present(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b1, 5'd3);
    check("ori_data", ex_wrdata, 32'h0000_00FF);
    check("ori_ex_wreg", ex_wreg, 1'b1);
    check("ori_stall", ex_stallreq, 1'b0);
    step();
    check("ori_mem_data", mem_wrdata, 32'h0000_00FF);
    check("ori_mem_wraddr", mem_wraddr, 5'd3);
    check("ori_mem_wreg", mem_wreg, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
